// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan controller: FSM states,
// shift-register mode select, LFSR/MISR tap masks and the default seed.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_e;

    typedef enum logic {
        MODE_LFSR,
        MODE_MISR
    } lfsr_mode_e;

    // LFSR feedback taps: bits 0,2,3,5 (right-shifting register)
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    // MISR feedback taps: bits 15,13,12,10 (left-shifting register)
    localparam logic [15:0] MISR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // An all-zero LFSR never leaves zero, so a zero seed is replaced.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/scan_lfsr16.sv
// 16-bit shift register used either as the pattern LFSR or as the
// response-compacting MISR. init_i reloads INIT_VAL (also the reset value);
// step_i advances one step in the selected mode. Only the low OUT_W bits
// are exported so the LFSR instance can expose just its serial bit.
module scan_lfsr16
    import scan_ctrl_pkg::*;
#(
    parameter logic [15:0] INIT_VAL = 16'h0001,
    parameter int          OUT_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  lfsr_mode_e       mode_i,
    input  logic             init_i,
    input  logic             step_i,
    input  logic             din_i,
    output logic [OUT_W-1:0] q_o
);

    logic [15:0] reg_q, reg_d;
    logic        fb;

    // Next value: reload has priority over stepping
    always_comb begin
        reg_d = reg_q;
        fb    = 1'b0;
        if (init_i) begin
            reg_d = INIT_VAL;
        end else if (step_i) begin
            if (mode_i == MODE_LFSR) begin
                fb    = ^(reg_q & LFSR_TAPS);
                reg_d = {fb, reg_q[15:1]};
            end else begin
                fb    = ^(reg_q & MISR_TAPS);
                reg_d = {reg_q[14:0], fb ^ din_i};
            end
        end
    end

    // Register with synchronous reset to INIT_VAL
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            reg_q <= INIT_VAL;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q_o = reg_q[OUT_W-1:0];

endmodule

// File: rtl/scan_ctrl.sv
// Scan test sequencer: shifts LFSR patterns into a scan chain, pulses
// capture, compacts the returning data into a MISR and compares the final
// signature with golden.
// Build option: define SCAN_LAUNCH_EN for a 2-cycle (launch-on-capture)
// CAPTURE state; otherwise CAPTURE is a single cycle.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start; signature holds the last result
//   SHIFT   | CHAIN_LEN cycles shifting a pattern in / response out
//   CAPTURE | scan_en low so the chain captures the circuit response
//   UNLOAD  | CHAIN_LEN cycles flushing the last response into the MISR
//   DONE    | one-cycle done pulse with pass valid
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int          CHAIN_LEN = 64,
    parameter int          NUM_PAT   = 32,
    parameter logic [15:0] SEED      = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] golden,
    input  logic        scan_out0,
    output logic        scan_en,
    output logic        scan_in0,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        pass
);

`ifdef SCAN_LAUNCH_EN
    localparam int CAP_CYCLES = 2;
`else
    localparam int CAP_CYCLES = 1;
`endif

    localparam int              SW         = $clog2(CHAIN_LEN + 1);
    localparam int              PW         = $clog2(NUM_PAT + 1);
    localparam logic [15:0]     SEED_EFF   = seed_fix(SEED);
    localparam logic [SW-1:0]   SHIFT_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [SW-1:0]   CAP_LAST   = SW'(CAP_CYCLES - 1);
    localparam logic [PW-1:0]   PAT_FULL   = PW'(NUM_PAT);

    scan_state_e   state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;    // cycles left in current SHIFT/CAPTURE/UNLOAD
    logic [PW-1:0] pat_q, pat_d;    // patterns left, including the current one
    logic          lfsr_init, lfsr_step, misr_init, misr_step;
    logic          lfsr_bit;
    logic [15:0]   misr_q;

    scan_lfsr16 #(.INIT_VAL(SEED_EFF), .OUT_W(1)) u_lfsr (
        .clk_i   (clk),
        .reset_i (reset),
        .mode_i  (MODE_LFSR),
        .init_i  (lfsr_init),
        .step_i  (lfsr_step),
        .din_i   (1'b0),
        .q_o     (lfsr_bit)
    );

    scan_lfsr16 #(.INIT_VAL(16'h0000), .OUT_W(16)) u_misr (
        .clk_i   (clk),
        .reset_i (reset),
        .mode_i  (MODE_MISR),
        .init_i  (misr_init),
        .step_i  (misr_step),
        .din_i   (scan_out0),
        .q_o     (misr_q)
    );

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
        end
    end

    // Next state, counter updates and Moore outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        lfsr_init = 1'b0;
        lfsr_step = 1'b0;
        misr_init = 1'b0;
        misr_step = 1'b0;
        scan_en   = 1'b0;
        scan_in0  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    cnt_d     = SHIFT_LAST;
                    pat_d     = PAT_FULL;
                    lfsr_init = 1'b1;
                    misr_init = 1'b1;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                scan_in0  = lfsr_bit;
                lfsr_step = 1'b1;
                // the chain holds no response yet while loading pattern 1
                misr_step = (pat_q != PAT_FULL);
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                    cnt_d   = CAP_LAST;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    pat_d   = pat_q - PW'(1);
                    cnt_d   = SHIFT_LAST;
                    state_d = (pat_q == PW'(1)) ? UNLOAD : SHIFT;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            UNLOAD: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                misr_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                pass    = (misr_q == golden);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign signature = misr_q;

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: scan chain length in flops, >= 2.
REQ-002 SHALL have parameter NUM_PAT, default 32: patterns per run, >= 1.
REQ-003 SHALL have parameter SEED, default 16'hACE1: LFSR seed; a value of 0 is replaced by 16'h0001.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-007 SHALL have port golden, input, 16 bits: expected signature.
REQ-008 SHALL have port scan_out0, input, 1 bit: serial data from the DUT chain tail.
REQ-009 SHALL have port scan_en, output, 1 bit: DUT shift enable.
REQ-010 SHALL have port scan_in0, output, 1 bit: serial data to the DUT chain head.
REQ-011 SHALL have port busy, output, 1 bit: run in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-013 SHALL have port signature, output, 16 bits: MISR value, held after the run.
REQ-014 SHALL have port pass, output, 1 bit: valid with done, and equals (signature==golden).

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-016 IDLE with start=1 SHALL go to SHIFT next cycle, clear the MISR, and load the LFSR with SEED.
REQ-017 SHIFT SHALL last exactly CHAIN_LEN cycles with scan_en=1, scan_in0=lfsr[0], and the LFSR stepping every cycle.
REQ-018 LFSR step SHALL be: fb=l[0]^l[2]^l[3]^l[5]; l={fb,l[15:1]}.
REQ-019 MISR step SHALL be: fb=m[15]^m[13]^m[12]^m[10]; m={m[14:0], fb^scan_out0}.
REQ-020 MISR SHALL step on every SHIFT cycle except those of the first pattern; it SHALL also step on every UNLOAD cycle.
REQ-021 CAPTURE SHALL be 1 cycle with scan_en=0 and scan_in0=0, then go to SHIFT if patterns remain, else UNLOAD.
REQ-022 UNLOAD SHALL last CHAIN_LEN cycles with scan_en=1 and scan_in0=0, then go to DONE.
REQ-023 DONE SHALL last 1 cycle with done=1 and pass valid, then go to IDLE.
REQ-024 busy SHALL be 1 in SHIFT, CAPTURE and UNLOAD; 0 in IDLE and DONE.
REQ-025 Run length SHALL be NUM_PAT*(CHAIN_LEN+1)+CHAIN_LEN busy cycles; done SHALL assert one cycle later.
REQ-026 start while not in IDLE SHALL be ignored; start held high through DONE SHALL retrigger a run from IDLE.
REQ-027 signature SHALL track the MISR continuously and hold its final value until the next start.
REQ-028 Pattern and shift counters SHALL be sized $clog2(NUM_PAT+1) and $clog2(CHAIN_LEN+1).

Reset
REQ-029 reset SHALL force IDLE with scan_en=0, scan_in0=0, busy=0, done=0, pass=0, signature=0, all counters=0 and lfsr=SEED.
REQ-030 reset asserted mid-run SHALL abort the run without a done pulse, with outputs at reset values the next cycle.
REQ-031 reset SHALL take priority over start.

Configuration
REQ-032 When macro SCAN_LAUNCH_EN is defined, CAPTURE SHALL last 2 cycles (launch-on-capture), adding NUM_PAT cycles to the run.
REQ-033 When SCAN_LAUNCH_EN is undefined, CAPTURE SHALL last 1 cycle.

Structure
REQ-034 Package scan_ctrl_pkg SHALL hold the state enum, the LFSR/MISR tap constants and the default SEED.
REQ-035 One sub-module, scan_lfsr16, SHALL implement both the LFSR and the MISR, selected by a mode input; it SHALL be instantiated twice.

Verification
REQ-036 Reset check: after reset with start=0 for 5 cycles, all outputs SHALL be 0.
REQ-037 Timing check (CHAIN_LEN=8, NUM_PAT=2, start sampled at edge k): scan_en SHALL be 0 only at k+9 and k+18; busy SHALL be high k+1..k+26; done SHALL pulse at k+27.
REQ-038 Stimulus check: the first 8 scan_in0 bits SHALL be 1,0,0,0,0,1,1,1 (SEED LSB first).
REQ-039 Loopback check (8-flop shift-register DUT model): signature SHALL equal the bench model; golden=model SHALL give pass=1, and golden=model^1 SHALL give pass=0.
REQ-040 Abort and retrigger check: reset at k+5 SHALL give busy=0, scan_en=0 and no done pulse; start pulsed at k+12 of a run SHALL be ignored.
REQ-041 SCAN_LAUNCH_EN check (same parameters as REQ-037): scan_en SHALL be low at k+9..k+10 and k+19..k+20, and done SHALL pulse at k+29.
